// File: rtl/div_seq_pkg.sv
// -----------------------------------------------------------------------------
// div_seq_pkg
// Shared definitions for the sequential HI/LO divider.
//   DIV_WIDTH    default operand/result width
//   DIV_CNT_W    iteration counter width for the default width
//   div_state_e  sequencer states
// -----------------------------------------------------------------------------
package div_seq_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DZERO = 2'd1,
        ST_ON    = 2'd2,
        ST_END   = 2'd3
    } div_state_e;

endpackage : div_seq_pkg

// File: rtl/div_seq_step.sv
// -----------------------------------------------------------------------------
// div_step
// One restoring-division step, purely combinational.
//   rem_i  partial remainder so far (always < dvs_i)
//   bit_i  next dividend bit, MSB first
//   dvs_i  divisor magnitude (non-zero)
//   rem_o  new partial remainder
//   q_o    quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    always_comb begin
        shifted = {rem_i, bit_i};
        // The true difference is below 2^WIDTH whenever the subtraction is
        // taken, so a WIDTH-bit wraparound subtract is exact.
        diff    = shifted[WIDTH-1:0] - dvs_i;
        q_o     = shifted[WIDTH] | (shifted[WIDTH-1:0] >= dvs_i);
        rem_o   = q_o ? diff : shifted[WIDTH-1:0];
    end

endmodule : div_step

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq
// Multi-cycle DIV/DIVU sequencer producing one quotient bit per cycle.
//   clk       system clock, rising edge
//   rst       synchronous active-low reset
//   start_i   begin a divide (honoured only in IDLE)
//   signed_i  1 = signed (DIV), 0 = unsigned (DIVU); captured with start
//   annul_i   cancel an in-flight divide (ON or DZERO)
//   opa_i     dividend, captured with start
//   opb_i     divisor, captured with start
//   stall_o   hold the pipeline front-end and EX
//   ready_o   one-cycle pulse when hi_o/lo_o carry a new result
//   lo_o      quotient register
//   hi_o      remainder register
// -----------------------------------------------------------------------------
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic             stall_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] rem_q,   rem_d;    // partial remainder
    logic [WIDTH-1:0] quo_q,   quo_d;    // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs_q,   dvs_d;    // divisor magnitude
    logic             q_neg_q, q_neg_d;  // negate quotient at the end
    logic             r_neg_q, r_neg_d;  // negate remainder at the end
    logic [WIDTH-1:0] lo_q,    lo_d;
    logic [WIDTH-1:0] hi_q,    hi_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] quo_next;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .bit_i (quo_q[WIDTH-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // Operand magnitudes and signs, taken straight from the ports at start.
    always_comb begin
        a_neg    = signed_i & opa_i[WIDTH-1];
        b_neg    = signed_i & opb_i[WIDTH-1];
        a_mag    = a_neg ? -opa_i : opa_i;
        b_mag    = b_neg ? -opb_i : opb_i;
        quo_next = {quo_q[WIDTH-2:0], step_q};
    end

    // NOTE: every signal assigned here gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        lo_d    = lo_q;
        hi_d    = hi_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
                    state_d = (opb_i == '0) ? ST_DZERO : ST_ON;
                end
            end

            ST_DZERO: begin
                if (annul_i) begin
                    state_d = ST_IDLE;
                end else begin
                    lo_d    = '0;
                    hi_d    = '0;
                    state_d = ST_END;
                end
            end

            ST_ON: begin
                // Annul takes priority, including over the final step.
                if (annul_i) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = quo_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        // Results land on the edge that enters END so they
                        // are valid in the same cycle as ready_o.
                        lo_d    = q_neg_q ? -quo_next : quo_next;
                        hi_d    = r_neg_q ? -step_rem : step_rem;
                        state_d = ST_END;
                    end
                end
            end

            ST_END: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: all state, datapath included, is reset so nothing is undefined
    // after reset; the cost is negligible for a handful of registers.
    // NOTE: non-blocking assignments only, so every register samples the
    // pre-edge values computed above regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    // The start term is qualified by rst so a start held during reset does
    // not stall the pipeline; END drops stall so the instruction advances
    // together with ready_o.
    always_comb begin
        stall_o = ((state_q == ST_IDLE) && start_i && rst) ||
                  (state_q == ST_ON) || (state_q == ST_DZERO);
        ready_o = (state_q == ST_END);
        lo_o    = lo_q;
        hi_o    = hi_q;
    end

endmodule : div_seq

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle sequencer for HI/LO divide operations (DIV/DIVU), one quotient bit per cycle.
- Sits in EX beside the ALU. Decode raises start and sign; this block captures the operands, stalls the pipeline while iterating, then presents quotient (LO) and remainder (HI) with a one-cycle ready pulse.
- Annul cancels an in-flight divide when the issuing instruction is flushed.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset. rst=0 at a rising edge resets the block.
- start_i  in  1  begin divide; sampled only in IDLE.
- signed_i  in  1  1 = signed divide (DIV), 0 = unsigned (DIVU); captured with start.
- annul_i  in  1  abort the in-flight divide.
- opa_i  in  WIDTH  dividend, captured with start.
- opb_i  in  WIDTH  divisor, captured with start.
- stall_o  out  1  hold the pipeline front-end and EX.
- ready_o  out  1  one-cycle pulse when hi_o/lo_o hold a new result.
- lo_o  out  WIDTH  quotient register.
- hi_o  out  WIDTH  remainder register.

Behaviour:
- Reset values: state=IDLE, counter=0, stall_o=0, ready_o=0, lo_o=0, hi_o=0.
- States:
  - IDLE:
    - start_i=1, opb_i≠0 -> ON; counter=0.
    - start_i=1, opb_i=0 -> DZERO.
    - Otherwise remain in IDLE.
  - DZERO: exactly one cycle -> END with result LO=0, HI=0.
  - ON: one restoring step per cycle, counter increments.
    - When counter reaches WIDTH-1 -> END.
    - annul_i=1 -> IDLE.
  - END: ready_o=1 for this cycle only; result registers updated on entry; -> IDLE.
- Latency:
  - Start sampled at edge 0.
  - ON occupies edges 1..WIDTH; END is the cycle after edge WIDTH. ready_o is high in the 33rd cycle after start for WIDTH=32.
  - Divide-by-zero: ready_o is high in the 2nd cycle after start.
- stall_o:
  - Combinational; 1 when (state=IDLE and start_i=1), or state is ON or DZERO.
  - 0 in END, so the stalled instruction advances together with ready_o.
- Signed arithmetic:
  - Operate on magnitudes.
  - Quotient is negated when operand signs differ.
  - Remainder takes the sign of the dividend.
  - Signs and magnitudes are captured at start, so input changes during ON are ignored.
- Unsigned mode: no sign handling.
- Overflow case 0x80000000 / 0xFFFFFFFF signed: LO=0x80000000, HI=0. No trap.
- start_i outside IDLE is ignored; no queueing.
- Annul:
  - In ON or DZERO: return to IDLE at the next edge, no ready pulse, hi_o/lo_o keep their previous values.
  - annul_i in IDLE or END has no effect.
- Simultaneous annul and final step: annul wins.
- rst=0 mid-divide: immediate return to reset values at that edge.
- hi_o/lo_o hold the last completed result indefinitely.

Decomposition:
- Shared package holds:
  - state enum (IDLE, DZERO, ON, END)
  - WIDTH default
  - counter width constant $clog2(WIDTH)
- Sub-module div_step: purely combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new partial remainder, quotient bit.
- div_seq owns the FSM, counter, operand/sign capture, sign fix-up and result registers.

Test Plan:
- Unsigned 100/7, signed_i=0:
  - stall_o=1 for 33 cycles starting at the start cycle.
  - ready_o pulses in cycle 33 with LO=14, HI=2.
- Signed -7/2 (0xFFFFFFF9, 0x00000002):
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Also cover 7/-2: LO=0xFFFFFFFD, HI=1.
- Divide by zero (opa=5, opb=0): ready_o pulses 2 cycles after start with LO=0, HI=0; stall_o=1 only in the first of those cycles.
- Annul at iteration 10 of 50/5 (previous result LO=14, HI=2):
  - Block returns to IDLE next cycle with no ready pulse.
  - hi/lo stay at 2/14.
  - A new start is accepted on the following cycle.
- rst=0 asserted at iteration 20: all outputs are 0 and state is IDLE at that edge; a start held during reset is ignored.
- start_i pulsed again during ON, with different operands: no effect; the original result completes at the original cycle.
